// File: rtl/core_ldst_pipe_pkg.sv
// Shared types for the pipelined load/store unit: bus words, decode and
// writeback records, access size encoding and the queue entry layout.
package core_ldst_pipe_pkg;

    typedef logic [31:0] word;
    typedef logic [15:0] hword;
    typedef logic [29:0] ptr;

    localparam int RD_W = 4;

    typedef enum logic [1:0] {
        LDST_BYTE = 2'd0,
        LDST_HALF = 2'd1,
        LDST_WORD = 2'd2
    } ldst_size;

    typedef struct packed {
        logic            writeback;
        logic [RD_W-1:0] rd;
    } insn_data;

    typedef struct packed {
        insn_data data;
    } insn_decode;

    typedef struct packed {
        logic            ready;
        logic [RD_W-1:0] rd;
        word             value;
    } wb_line;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic            load;
        logic [1:0]      off;
        ldst_size        size;
        logic            sign_ext;
        logic            done;
        word             data;
    } ldst_entry;

    // Clear the offset bits that would make an access misaligned.
    function automatic logic [1:0] align_off(input ldst_size sz, input logic [1:0] off);
        case (sz)
            LDST_BYTE: return off;
            LDST_HALF: return {off[1], 1'b0};
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/core_ldst_lanes.sv
// Byte-lane logic: store byte enables and lane replication on the issue
// side, load alignment and extension on the retire side.
module core_ldst_lanes
    import core_ldst_pipe_pkg::*;
(
    input  logic [1:0] st_off_i,
    input  ldst_size   st_size_i,
    input  word        st_data_i,
    output logic [3:0] be_o,
    output word        wr_data_o,
    input  logic [1:0] ld_off_i,
    input  ldst_size   ld_size_i,
    input  logic       ld_sext_i,
    input  word        ld_data_i,
    output word        ld_value_o
);

    word sh;

    // Store side: enables shifted to the addressed lanes, data copied to all lanes.
    always_comb begin
        be_o      = 4'b1111;
        wr_data_o = st_data_i;
        case (st_size_i)
            LDST_BYTE: begin
                be_o      = 4'b0001 << st_off_i;
                wr_data_o = {4{st_data_i[7:0]}};
            end
            LDST_HALF: begin
                be_o      = 4'b0011 << st_off_i;
                wr_data_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: bring the addressed lanes down to bit 0, then extend.
    always_comb begin
        sh         = ld_data_i >> {ld_off_i, 3'b000};
        ld_value_o = sh;
        case (ld_size_i)
            LDST_BYTE: ld_value_o = {{24{ld_sext_i & sh[7]}}, sh[7:0]};
            LDST_HALF: ld_value_o = {{16{ld_sext_i & sh[15]}}, sh[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/core_raw_mask.sv
// One-hot pending-destination mask for a single register write; r0 never
// creates a hazard.
module core_raw_mask
    import core_ldst_pipe_pkg::*;
(
    input  logic            en_i,
    input  logic [RD_W-1:0] rd_i,
    output hword            mask_o
);

    // Set the destination bit when enabled and not r0.
    always_comb begin
        mask_o = '0;
        if (en_i && (rd_i != '0)) begin
            mask_o[rd_i] = 1'b1;
        end
    end

endmodule

// File: rtl/core_ldst_pipe.sv
// Pipelined load/store unit: holds up to DEPTH in-order bus transactions,
// retires them to writeback in issue order and reports pending load
// destinations. Build option LDST_MISALIGN_TRAP_EN turns misaligned accesses
// into a fault pulse instead of silently aligning them.
module core_ldst_pipe
    import core_ldst_pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int BUS_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  insn_decode dec,
    input  logic       start,
    input  ldst_size   size,
    input  logic       sign_ext,
    input  word        a,
    input  word        b,
    input  logic       data_ready,
    input  word        data_data_rd,
    input  logic       wb_stall,
    output wb_line     wb,
    output hword       raw_mask,
    output ptr         data_addr,
    output word        data_data_wr,
    output logic [3:0] data_data_be,
    output logic       data_start,
    output logic       data_write,
    output logic       ldst_wait,
    output logic       fault
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    if (BUS_W != 32) begin : g_bus_w_chk
        $error("core_ldst_pipe: BUS_W must be 32");
    end
    if ((DEPTH < 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("core_ldst_pipe: DEPTH must be a power of two");
    end

    // Pointer advance that wraps modulo DEPTH.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (DEPTH == 1) return '0;
        return p + 1'b1;
    endfunction

    ldst_entry        ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, resp_q, resp_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic            data_start_q, data_write_q;
    ptr              data_addr_q;
    word             data_wr_q;
    logic [3:0]      data_be_q;
    logic            wb_ready_q;
    logic [RD_W-1:0] wb_rd_q;
    word             wb_value_q;

    logic       is_load, accept, push, pop, resp_hit, bypass;
    word        addr, head_data, st_wr, ld_value;
    logic [1:0] off_raw, off_eff;
    logic [3:0] st_be;
    ldst_entry  head_ent;

    assign is_load   = dec.data.writeback;
    assign addr      = is_load ? a : b;
    assign off_raw   = addr[1:0];
    assign ldst_wait = (cnt_q == CW'(DEPTH)) || wb_stall;
    assign accept    = start && !ldst_wait;

`ifdef LDST_MISALIGN_TRAP_EN
    logic misaligned, fault_q;
    assign misaligned = ((size == LDST_HALF) && off_raw[0]) ||
                        ((size == LDST_WORD) && (off_raw != 2'b00));
    assign off_eff    = off_raw;
    assign push       = accept && !misaligned;
    assign fault      = fault_q;

    // Fault pulse one cycle after a misaligned start, independent of stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= start && misaligned;
    end
`else
    assign off_eff = align_off(size, off_raw);
    assign push    = accept;
    assign fault   = 1'b0;
`endif

    // A response lands on the oldest not-done entry; if that entry is the
    // head it can retire in the same cycle, giving the two-cycle load latency.
    assign head_ent  = ent_q[head_q];
    assign resp_hit  = data_ready && vld_q[resp_q] && !ent_q[resp_q].done;
    assign bypass    = resp_hit && (resp_q == head_q);
    assign pop       = vld_q[head_q] && (head_ent.done || bypass) && !wb_stall;
    assign head_data = head_ent.done ? head_ent.data : data_data_rd;

    core_ldst_lanes u_lanes (
        .st_off_i   (off_eff),
        .st_size_i  (size),
        .st_data_i  (a),
        .be_o       (st_be),
        .wr_data_o  (st_wr),
        .ld_off_i   (head_ent.off),
        .ld_size_i  (head_ent.size),
        .ld_sext_i  (head_ent.sign_ext),
        .ld_data_i  (head_data),
        .ld_value_o (ld_value)
    );

    hword ent_mask [DEPTH];
    hword in_mask;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent_mask
        core_raw_mask u_mask (
            .en_i   (vld_q[i] && ent_q[i].load),
            .rd_i   (ent_q[i].rd),
            .mask_o (ent_mask[i])
        );
    end

    core_raw_mask u_in_mask (
        .en_i   (start && is_load),
        .rd_i   (dec.data.rd),
        .mask_o (in_mask)
    );

    // Merge pending-load destinations with the one being issued.
    always_comb begin
        raw_mask = in_mask;
        for (int i = 0; i < DEPTH; i++) begin
            raw_mask = raw_mask | ent_mask[i];
        end
    end

    // Queue bookkeeping: push at tail, pop at head, response pointer apart.
    always_comb begin
        vld_d  = vld_q;
        head_d = head_q;
        tail_d = tail_q;
        resp_d = resp_q;
        cnt_d  = cnt_q;
        if (push) begin
            vld_d[tail_q] = 1'b1;
            tail_d        = ptr_inc(tail_q);
        end
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = ptr_inc(head_q);
        end
        if (resp_hit) begin
            resp_d = ptr_inc(resp_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: ;
        endcase
    end

    // Control state and output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            resp_q       <= '0;
            cnt_q        <= '0;
            data_start_q <= 1'b0;
            wb_ready_q   <= 1'b0;
        end else begin
            vld_q        <= vld_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            resp_q       <= resp_d;
            cnt_q        <= cnt_d;
            data_start_q <= push;
            wb_ready_q   <= pop && head_ent.load;
        end
    end

    // Entry payloads: filled on push, completed by the in-order response.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_q[tail_q] <= '{rd: dec.data.rd, load: is_load, off: off_eff, size: size,
                               sign_ext: sign_ext, done: 1'b0, data: '0};
        end
        if (resp_hit) begin
            ent_q[resp_q].done <= 1'b1;
            ent_q[resp_q].data <= data_data_rd;
        end
    end

    // Bus request and writeback payload registers.
    always_ff @(posedge clk) begin
        if (push) begin
            data_addr_q  <= addr[31:2];
            data_write_q <= !is_load;
            data_be_q    <= st_be;
            data_wr_q    <= st_wr;
        end
        if (pop && head_ent.load) begin
            wb_rd_q    <= head_ent.rd;
            wb_value_q <= ld_value;
        end
    end

    // Responses are only legal while a request is outstanding.
    always @(posedge clk) begin
        if (rst_n && data_ready) begin
            assert (vld_q[resp_q] && !ent_q[resp_q].done)
                else $error("core_ldst_pipe: data_ready with no outstanding request");
        end
    end

    assign data_start   = data_start_q;
    assign data_addr    = data_addr_q;
    assign data_write   = data_write_q;
    assign data_data_be = data_be_q;
    assign data_data_wr = data_wr_q;
    assign wb           = {wb_ready_q, wb_rd_q, wb_value_q};

endmodule

// File: tb/tb_core_ldst_pipe.sv
// Directed bench for core_ldst_pipe with a scoreboard of expected bus
// requests and writeback results.
module tb_core_ldst_pipe;
    import core_ldst_pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    insn_decode dec;
    logic       start, sign_ext, data_ready, wb_stall;
    ldst_size   size;
    word        a, b, data_data_rd;
    wb_line     wb;
    hword       raw_mask;
    ptr         data_addr;
    word        data_data_wr;
    logic [3:0] data_data_be;
    logic       data_start, data_write, ldst_wait, fault;

    always #5 clk = ~clk;

    core_ldst_pipe #(.DEPTH(2), .BUS_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec          (dec),
        .start        (start),
        .size         (size),
        .sign_ext     (sign_ext),
        .a            (a),
        .b            (b),
        .data_ready   (data_ready),
        .data_data_rd (data_data_rd),
        .wb_stall     (wb_stall),
        .wb           (wb),
        .raw_mask     (raw_mask),
        .data_addr    (data_addr),
        .data_data_wr (data_data_wr),
        .data_data_be (data_data_be),
        .data_start   (data_start),
        .data_write   (data_write),
        .ldst_wait    (ldst_wait),
        .fault        (fault)
    );

    typedef struct {
        logic [29:0] addr;
        logic        wr;
        logic [3:0]  be;
        word         wd;
    } bus_exp_t;

    typedef struct {
        logic [3:0] rd;
        word        val;
    } wb_exp_t;

    bus_exp_t bus_q[$];
    wb_exp_t  wbq[$];
    bus_exp_t me;
    wb_exp_t  mw;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one access and record what the bus and writeback must show.
    task automatic drive_issue(input bit ld, input logic [3:0] rd, input ldst_size sz,
                               input bit sx, input word av, input word bv,
                               input logic [3:0] ebe, input word ewr, input word ewb,
                               input bit expect_bus);
        bus_exp_t be_e;
        wb_exp_t  wb_e;
        start             = 1'b1;
        dec.data.writeback = ld;
        dec.data.rd       = rd;
        size              = sz;
        sign_ext          = sx;
        a                 = av;
        b                 = bv;
        if (expect_bus) begin
            be_e.addr = ld ? av[31:2] : bv[31:2];
            be_e.wr   = !ld;
            be_e.be   = ebe;
            be_e.wd   = ewr;
            bus_q.push_back(be_e);
            if (ld) begin
                wb_e.rd  = rd;
                wb_e.val = ewb;
                wbq.push_back(wb_e);
            end
        end
    endtask

    // Scoreboard: every bus request and every writeback pops its expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_start) begin
                chk("data_start_expected", 32'(bus_q.size() != 0), 32'd1);
                if (bus_q.size() != 0) begin
                    me = bus_q.pop_front();
                    chk("data_addr", {2'b00, data_addr}, {2'b00, me.addr});
                    chk("data_write", {31'd0, data_write}, {31'd0, me.wr});
                    chk("data_be", {28'd0, data_data_be}, {28'd0, me.be});
                    chk("data_wr", data_data_wr, me.wd);
                end
            end
            if (wb.ready) begin
                chk("wb_expected", 32'(wbq.size() != 0), 32'd1);
                if (wbq.size() != 0) begin
                    mw = wbq.pop_front();
                    chk("wb_rd", {28'd0, wb.rd}, {28'd0, mw.rd});
                    chk("wb_value", wb.value, mw.val);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; dec = '0; size = LDST_WORD; sign_ext = 1'b0;
        a = '0; b = '0; data_ready = 1'b0; data_data_rd = '0; wb_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_start", {31'd0, data_start}, 32'd0);
        chk("rst_wb_ready", {31'd0, wb.ready}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_ldst_wait", {31'd0, ldst_wait}, 32'd0);
        chk("rst_raw_mask", {16'd0, raw_mask}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Word load, rd=5
        drive_issue(1, 4'd5, LDST_WORD, 0, 32'h100, 32'h0, 4'b1111, 32'h100, 32'hDEADBEEF, 1);
        #1 chk("t1_raw_in", {16'd0, raw_mask}, 32'h0020);
        tick();
        start = 1'b0; data_ready = 1'b1; data_data_rd = 32'hDEADBEEF;
        #1 chk("t1_data_start", {31'd0, data_start}, 32'd1);
        chk("t1_raw_pending", {16'd0, raw_mask}, 32'h0020);
        chk("t1_wb_early", {31'd0, wb.ready}, 32'd0);
        tick();
        data_ready = 1'b0;
        #1 chk("t1_wb_ready", {31'd0, wb.ready}, 32'd1);
        chk("t1_raw_clear", {16'd0, raw_mask}, 32'd0);
        tick();
        #1 chk("t1_wb_pulse", {31'd0, wb.ready}, 32'd0);

        // Byte loads from 0x103, signed then unsigned
        drive_issue(1, 4'd6, LDST_BYTE, 1, 32'h103, 32'h0, 4'b1000, 32'h03030303, 32'hFFFFFF80, 1);
        tick();
        drive_issue(1, 4'd7, LDST_BYTE, 0, 32'h103, 32'h0, 4'b1000, 32'h03030303, 32'h00000080, 1);
        data_ready = 1'b1; data_data_rd = 32'h80FFFFFF;
        #1 chk("t2_raw", {16'd0, raw_mask}, 32'h00C0);
        tick();
        start = 1'b0;
        #1 chk("t2_wb_first", {31'd0, wb.ready}, 32'd1);
        tick();
        data_ready = 1'b0;
        #1 chk("t2_wb_second", {31'd0, wb.ready}, 32'd1);
        tick();
        #1 chk("t2_wb_done", {31'd0, wb.ready}, 32'd0);

        // Half store to 0x202
        drive_issue(0, 4'd0, LDST_HALF, 0, 32'h1234, 32'h202, 4'b1100, 32'h12341234, 32'h0, 1);
        #1 chk("t3_raw", {16'd0, raw_mask}, 32'd0);
        tick();
        start = 1'b0; data_ready = 1'b1; data_data_rd = 32'h0;
        #1 chk("t3_data_write", {31'd0, data_write}, 32'd1);
        tick();
        data_ready = 1'b0;
        #1 chk("t3_no_wb_a", {31'd0, wb.ready}, 32'd0);
        tick();
        #1 chk("t3_no_wb_b", {31'd0, wb.ready}, 32'd0);

        // Queue full: third load waits until one response retires
        drive_issue(1, 4'd1, LDST_WORD, 0, 32'h10, 32'h0, 4'b1111, 32'h10, 32'h11111111, 1);
        tick();
        drive_issue(1, 4'd2, LDST_WORD, 0, 32'h20, 32'h0, 4'b1111, 32'h20, 32'h22222222, 1);
        #1 chk("t4_wait_one", {31'd0, ldst_wait}, 32'd0);
        tick();
        drive_issue(1, 4'd3, LDST_WORD, 0, 32'h30, 32'h0, 4'b1111, 32'h30, 32'h33333333, 1);
        #1 chk("t4_wait_full", {31'd0, ldst_wait}, 32'd1);
        chk("t4_raw", {16'd0, raw_mask}, 32'h000E);
        chk("t4_second_start", {31'd0, data_start}, 32'd1);
        tick();
        #1 chk("t4_still_full", {31'd0, ldst_wait}, 32'd1);
        chk("t4_no_third_start", {31'd0, data_start}, 32'd0);
        data_ready = 1'b1; data_data_rd = 32'h11111111;
        tick();
        data_ready = 1'b0;
        #1 chk("t4_released", {31'd0, ldst_wait}, 32'd0);
        chk("t4_wb_l1", {31'd0, wb.ready}, 32'd1);
        tick();
        start = 1'b0;
        #1 chk("t4_third_start", {31'd0, data_start}, 32'd1);
        data_ready = 1'b1; data_data_rd = 32'h22222222;
        tick();
        data_data_rd = 32'h33333333;
        tick();
        data_ready = 1'b0;
        #1 chk("t4_wb_l3", {31'd0, wb.ready}, 32'd1);
        tick();
        #1 chk("t4_raw_clear", {16'd0, raw_mask}, 32'd0);

        // Writeback stall over two responses
        drive_issue(1, 4'd8, LDST_WORD, 0, 32'h40, 32'h0, 4'b1111, 32'h40, 32'hAAAA0001, 1);
        tick();
        drive_issue(1, 4'd9, LDST_WORD, 0, 32'h44, 32'h0, 4'b1111, 32'h44, 32'hBBBB0002, 1);
        tick();
        start = 1'b0; wb_stall = 1'b1; data_ready = 1'b1; data_data_rd = 32'hAAAA0001;
        #1 chk("t5_wait_stall", {31'd0, ldst_wait}, 32'd1);
        tick();
        data_data_rd = 32'hBBBB0002;
        #1 chk("t5_no_wb_a", {31'd0, wb.ready}, 32'd0);
        tick();
        data_ready = 1'b0;
        #1 chk("t5_no_wb_b", {31'd0, wb.ready}, 32'd0);
        chk("t5_raw", {16'd0, raw_mask}, 32'h0300);
        tick();
        wb_stall = 1'b0;
        #1 chk("t5_no_wb_c", {31'd0, wb.ready}, 32'd0);
        tick();
        #1 chk("t5_wb_first", {31'd0, wb.ready}, 32'd1);
        chk("t5_wb_rd8", {28'd0, wb.rd}, 32'd8);
        tick();
        #1 chk("t5_wb_second", {31'd0, wb.ready}, 32'd1);
        chk("t5_wb_rd9", {28'd0, wb.rd}, 32'd9);
        tick();
        #1 chk("t5_wb_done", {31'd0, wb.ready}, 32'd0);

        // Misaligned word load to 0x101
`ifdef LDST_MISALIGN_TRAP_EN
        drive_issue(1, 4'd10, LDST_WORD, 0, 32'h101, 32'h0, 4'b1111, 32'h101, 32'h0, 0);
        tick();
        start = 1'b0;
        #1 chk("t6_fault", {31'd0, fault}, 32'd1);
        chk("t6_no_start", {31'd0, data_start}, 32'd0);
        tick();
        #1 chk("t6_fault_pulse", {31'd0, fault}, 32'd0);
`else
        drive_issue(1, 4'd10, LDST_WORD, 0, 32'h101, 32'h0, 4'b1111, 32'h101, 32'h12345678, 1);
        tick();
        start = 1'b0; data_ready = 1'b1; data_data_rd = 32'h12345678;
        #1 chk("t6_data_start", {31'd0, data_start}, 32'd1);
        chk("t6_addr", {2'b00, data_addr}, 32'h40);
        chk("t6_be", {28'd0, data_data_be}, 32'hF);
        chk("t6_no_fault", {31'd0, fault}, 32'd0);
        tick();
        data_ready = 1'b0;
        #1 chk("t6_wb_ready", {31'd0, wb.ready}, 32'd1);
        chk("t6_wb_value", wb.value, 32'h12345678);
`endif

        repeat (3) tick();
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        chk("wb_q_drained", 32'(wbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_ldst_pipe.md
Name: core_ldst_pipe

Overview:
- Parametrised successor to the single-outstanding load/store unit.
- Supports byte, halfword and word accesses, with sign or zero extension on loads.
- Keeps up to DEPTH bus transactions in flight; the data bus must return responses in order.
- Sits between the issue stage and the data bus; load results go to the writeback port as a wb_line, and RAW hazard bits go to the hazard unit.

Parameters:
- DEPTH, 2: maximum transactions held in the queue (in flight or awaiting writeback); power of two, >=1.
- BUS_W, 32: data bus width in bits; 32 only for now, checked by elaboration assertion.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dec  in  insn_decode  decoded instruction; dec.data.writeback=1 means load, dec.data.rd is the destination
- start  in  1  issue strobe; accepted only when ldst_wait=0
- size  in  ldst_size  access size: LDST_BYTE, LDST_HALF, LDST_WORD
- sign_ext  in  1  sign-extend loaded byte/half
- a  in  word  load address / store data
- b  in  word  store address
- data_ready  in  1  one in-order bus response per pulse
- data_data_rd  in  word  read data, valid with data_ready
- wb_stall  in  1  writeback port busy
- wb  out  wb_line  load result; wb.ready is a 1-cycle pulse
- raw_mask  out  hword  pending-destination mask
- data_addr  out  ptr  word address, addr[31:2]
- data_data_wr  out  word  lane-replicated store data
- data_data_be  out  4  byte enables
- data_start  out  1  bus request pulse
- data_write  out  1  1 = store
- ldst_wait  out  1  issue back-pressure
- fault  out  1  misalignment pulse (optional feature only)

Behaviour:
- Reset values: data_start=0, wb.ready=0, fault=0, queue empty (count=0, head=tail=0). data_addr, data_data_wr, data_data_be, data_write and wb payload are X. Reset mid-operation discards all entries; the bus is reset alongside, so no stale data_ready arrives.
- Address: addr = load ? a : b; off = addr[1:0].
- ldst_wait = (count==DEPTH) || wb_stall. It uses the registered count, so a retire in the same cycle does not free a slot until the next cycle.
- Accept (start && !ldst_wait):
  - Push an entry {rd, load, off, size, sign_ext, done=0, data} at tail.
  - Next cycle: data_start=1 for exactly one cycle; data_addr, data_write=!load, data_data_be and data_data_wr are registered.
  - Back-to-back accepts issue back-to-back data_start pulses.
- Byte enables: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
- Store data: byte {4{a[7:0]}}; half {2{a[15:0]}}; word a.
- Response: data_ready marks the oldest not-done entry done and stores data_data_rd. The response pointer is separate from head.
  - data_ready with no outstanding request is an error: assertion, no state change.
- Retire, head entry only, when done && !wb_stall:
  - Store: popped silently.
  - Load: popped; next cycle wb.ready=1, wb.rd=rd, wb.value=extract(data).
  - extract: shift data right by off*8. Byte gives [7:0], half gives [15:0]; zero-extend, or sign-extend when sign_ext=1. Word passes through.
- Latency: a load accepted in cycle N, with data_ready in cycle N+1 and no stall, gives wb.ready in cycle N+2.
- raw_mask: OR of one-hot(rd) over valid load entries, plus the incoming dec.data.rd when start && load. rd=0 contributes nothing (same rule as core_raw_mask).
- Simultaneous accept and retire: count unchanged; both pointers advance.
- wb_stall: holds head and suppresses wb.ready. Responses are still absorbed into entries, so they are never lost.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: LDST_MISALIGN_TRAP_EN.
- Misaligned means half with off[0]=1, or word with off!=0.
- Defined: a misaligned start pushes nothing and issues no data_start. fault pulses the next cycle; it is not gated by wb_stall.
- Undefined: the fault port is tied to 0. A misaligned address has the offending low bits forced to 0 (half: off[0]=0; word: off=0), and the access proceeds as aligned.

Decomposition:
- core/uarch.sv gains:
  - typedef enum logic[1:0] ldst_size {LDST_BYTE, LDST_HALF, LDST_WORD}
  - typedef struct ldst_entry
- Sub-module core_ldst_lanes (combinational): computes be, store replication and load extract from {off, size, sign_ext}.
- Reuse core_raw_mask per entry.

Test Plan:
- Word load: a=0x100, data_ready next cycle with data 0xDEADBEEF, rd=5 -> data_addr=0x40, be=4'b1111, wb.ready 2 cycles after start, wb.value=0xDEADBEEF, raw_mask bit5 set until retire.
- Byte loads from 0x103, data 0x80FF_FFFF -> sign_ext=1 gives value 0xFFFFFF80; sign_ext=0 gives 0x00000080; be=4'b1000.
- Half store: b=0x202, a=0x1234 -> data_write=1, be=4'b1100, data_data_wr=0x12341234, no wb.ready.
- DEPTH=2: three back-to-back starts, no data_ready -> two data_start pulses, then ldst_wait=1; one data_ready plus retire releases the third the following cycle.
- wb_stall held 3 cycles while two load responses arrive -> no wb.ready; after release, results emerge in issue order on consecutive cycles.
- Word load to 0x101 -> with LDST_MISALIGN_TRAP_EN: fault pulse, no data_start; without it: data_addr=0x40, be=4'b1111.
